// File: rtl/g_4deser_pkg.sv
// g_4deser_pkg: shared types and frame sizing for g_4deser (G_4DESER_PARITY_EN adds a parity bit)
package g_4deser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DATA_W = 4;
`ifdef G_4DESER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
endpackage

// File: rtl/g_4deser_obuf.sv
// g_4deser_obuf: output holding register with valid/ready handshake and sticky overflow
module g_4deser_obuf
  import g_4deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              perr_in,
  input  logic              rdy,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] q,
  output logic              qv,
  output logic              perr,
  output logic              ovf
);
  logic [DATA_W-1:0] q_q, q_d;
  logic qv_q, qv_d, perr_q, perr_d, ovf_q, ovf_d, accept;
  always_comb begin
    accept = ~qv_q | rdy;
    q_d    = load && accept ? word : q_q;
    perr_d = load && accept ? perr_in : perr_q;
    qv_d   = load | (qv_q & ~rdy);
    ovf_d  = ovf_q | (load & ~accept);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      qv_q   <= 1'b0;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qv_q   <= qv_d;
      perr_q <= perr_d;
      ovf_q  <= ovf_d;
    end
  end
  assign q    = q_q;
  assign qv   = qv_q;
  assign perr = perr_q;
  assign ovf  = ovf_q;
endmodule

// File: rtl/g_4deser.sv
// g_4deser: serial-to-4-bit deserializer with SOF resync; G_4DESER_PARITY_EN adds a trailing odd-parity bit
module g_4deser
  import g_4deser_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic       CK,
  input  logic       CD,
  input  logic       SI,
  input  logic       SV,
  input  logic       SOF,
  input  logic       QR,
  output logic [3:0] Q,
  output logic       QV,
  output logic       PERR,
  output logic       OVF,
  output logic       BUSY
);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, idx;
  logic [1:0] pos;
  logic [DATA_W-1:0] data_q, data_d;
  logic done, perr_w;
  always_comb begin
    // a frame restarts at bit 0 from IDLE or on any valid SOF
    idx     = (SOF || state_q == IDLE) ? 3'd0 : cnt_q;
    pos     = LSB_FIRST != 0 ? idx[1:0] : 2'd3 - idx[1:0];
    data_d  = data_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (SV) begin
      if (idx == 3'd0) data_d = '0;
      if (idx < 3'(DATA_W)) data_d[pos] = SI;
      done    = idx == 3'(FRAME_LEN - 1);
      state_d = done ? IDLE : SHIFT;
      cnt_d   = done ? 3'd0 : idx + 3'd1;
    end
  end
`ifdef G_4DESER_PARITY_EN
  logic par_q, par_d;
  always_comb begin
    par_d  = SV ? ((idx == 3'd0 ? 1'b0 : par_q) ^ SI) : par_q;
    perr_w = ~par_d;
  end
  always_ff @(posedge CK) par_q <= CD ? 1'b0 : par_d;
`else
  assign perr_w = 1'b0;
`endif
  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  assign BUSY = state_q == SHIFT;
  g_4deser_obuf u_obuf (
    .clk(CK), .rst(CD), .load(done), .perr_in(perr_w), .rdy(QR),
    .word(data_d), .q(Q), .qv(QV), .perr(PERR), .ovf(OVF)
  );
endmodule

// File: doc/g_4deser.md
G_4DESER -- requirements
Module: g_4deser

Interface
REQ-001 Parameter LSB_FIRST, default 1: 1 = first received bit lands in Q[0]; 0 = first bit lands in Q[3].
REQ-002 CK  input  1  clock; all state changes on rising edge.
REQ-003 CD  input  1  reset, synchronous, active-high.
REQ-004 SI  input  1  serial data bit.
REQ-005 SV  input  1  SI valid this cycle.
REQ-006 SOF  input  1  SI is first bit of a frame; qualified by SV.
REQ-007 Q  output  4  deserialized word.
REQ-008 QV  output  1  Q valid; held until accepted.
REQ-009 QR  input  1  downstream ready; transfer when QV and QR both high.
REQ-010 PERR  output  1  parity error for the word on Q; meaningful only while QV=1.
REQ-011 OVF  output  1  sticky overflow flag.
REQ-012 BUSY  output  1  a frame is partially received.

Function
REQ-013 Frame length N SHALL be 4 data bits, or 5 bits (4 data + 1 parity last) with G_4DESER_PARITY_EN.
REQ-014 FSM SHALL have two states, IDLE and SHIFT; bit counter 0..N-1; BUSY = (state==SHIFT).
REQ-015 IDLE: SV=1 SHALL capture bit 0, counter=1 and go to SHIFT, regardless of SOF.
REQ-016 SHIFT: SV=1 and SOF=0 SHALL capture the next bit and increment the counter; SV=0 SHALL hold all state.
REQ-017 SV=1 and SOF=1 in any state SHALL discard the partial frame, capture SI as bit 0 and set counter=1 (resync); SOF with SV=0 SHALL be ignored.
REQ-018 On capture of bit N-1, the assembled word SHALL load into the output register, QV=1 the next cycle (latency 1 cycle from last bit), FSM to IDLE.
REQ-019 Output load SHALL be permitted when QV=0, or when QV=1 and QR=1 in the same cycle (drain and load simultaneous, QV stays 1).
REQ-020 Completion while QV=1 and QR=0 SHALL drop the new word, keep Q/QV/PERR unchanged, set OVF=1; OVF SHALL clear only on CD.
REQ-021 QV=1, QR=1, no completion: QV SHALL clear next cycle; Q SHALL hold its last value.
REQ-022 Q, PERR SHALL be stable while QV=1 and QR=0.
REQ-023 Parity (when enabled) SHALL be odd: PERR=1 when the XOR of 4 data bits and the parity bit equals 0; the word is still delivered.

Reset
REQ-024 CD=1 SHALL, at the next CK edge and with priority over all inputs: state=IDLE, counter=0, Q=4'b0000, QV=0, PERR=0, OVF=0, BUSY=0.
REQ-025 CD mid-frame or with QV pending SHALL discard both without producing a transfer.

Configuration
REQ-026 Macro G_4DESER_PARITY_EN defined: N=5, PERR computed per REQ-023.
REQ-027 Macro undefined: N=4, PERR tied 0, no parity logic.

Structure
REQ-028 Package g_4deser_pkg SHALL hold the FSM state typedef (IDLE, SHIFT), DATA_W=4, and FRAME_LEN (4 or 5 per macro).
REQ-029 Output holding register and QV/QR handshake SHALL be sub-module g_4deser_obuf; FSM, counter and shifter stay in g_4deser.

Verification
REQ-030 LSB_FIRST=1, no parity: SV=1 for 4 cycles with SI=1,0,1,1 and QR=1 -> cycle after 4th bit Q=4'b1101, QV=1 for one cycle, OVF=0.
REQ-031 Parity on: SI=1,1,0,0 then P=1 -> Q=4'b0011, PERR=0; repeat with P=0 -> PERR=1, word still delivered.
REQ-032 QR=0 held, two complete frames 4'hA then 4'h5 -> Q stays 4'hA, OVF=1; QR=1 -> QV drops next cycle, OVF stays 1.
REQ-033 After 2 bits of a frame, SV=1 with SOF=1 then 3 more bits (no parity) -> exactly one word, built from SOF bit onward; partial bits absent.
REQ-034 Completion on the same cycle as QR=1 with QV=1 -> old word transferred, new word loaded, QV stays 1, OVF=0.
REQ-035 CD=1 mid-frame with QV=1 -> next cycle all outputs 0; subsequent 4-bit frame delivered normally.
